// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the RV32M multiply/divide unit: funct3 opcode
//   encodings, the M-extension funct7 value, the control FSM state type and
//   small decode helpers used by both the control and datapath modules.
package muldiv_pkg;

   // funct7 that selects the M extension on an OP (0110011) instruction
   localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
   function automatic logic rs1_signed(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
             (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   // rs2 is treated as signed for MUL, MULH, DIV, REM
   function automatic logic rs2_signed(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) ||
             (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core
//   Iterative datapath for the multiply/divide unit. Works on operand
//   magnitudes and applies the sign at the end.
//   - Multiply: shift-add, one multiplier bit per step, 2*XLEN product.
//   - Divide:   restoring division, one quotient bit per step.
//   Ports:
//     clk_i, rst_i      clock, async active-high reset
//     start_i           latch operands/op (or the special-case result)
//     step_i            perform one iteration
//     finish_i          this step is the last: register the signed result
//     funct3_i          operation, sampled with start_i
//     rs1_i, rs2_i      operands, sampled with start_i
//     spec_i            start_i carries a precomputed special-case result
//     spec_res_i        that result
//     result_o          registered result, held until the next update
module muldiv_core
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            step_i,
   input  logic            finish_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            spec_i,
   input  logic [XLEN-1:0] spec_res_i,
   output logic [XLEN-1:0] result_o
);

   // acc: multiply -> {partial product hi, multiplier / product lo}
   //      divide   -> {partial remainder, dividend / quotient}
   logic [2*XLEN-1:0] acc_q, acc_d, acc_nxt, mul_nxt, div_nxt, prod_fix;
   logic [XLEN-1:0]   mb_q, mb_d, res_q, res_d;
   logic [XLEN-1:0]   mag1, mag2, div_sel, div_fix;
   logic              is_div_q, is_div_d, neg_q, neg_d, hi_q, hi_d;
   logic              s1, s2;
   logic [XLEN:0]     mul_sum, div_sh, div_diff;
   logic              div_ge;

   always_comb begin
      s1   = rs1_signed(funct3_i) & rs1_i[XLEN-1];
      s2   = rs2_signed(funct3_i) & rs2_i[XLEN-1];
      // -MIN wraps to 2^(XLEN-1), which is the correct unsigned magnitude
      mag1 = s1 ? -rs1_i : rs1_i;
      mag2 = s2 ? -rs2_i : rs2_i;

      // shift-add: add multiplicand to the high half if multiplier lsb set,
      // then shift the whole accumulator right (carry enters at the top)
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mb_q} : '0);
      mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

      // restoring step: shift in next dividend bit, subtract if it fits
      div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff = div_sh - {1'b0, mb_q};
      div_ge   = ~div_diff[XLEN];
      div_nxt  = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                  acc_q[XLEN-2:0], div_ge};

      acc_nxt  = is_div_q ? div_nxt : mul_nxt;

      // sign correction is taken from the post-step value so the result is
      // registered on the same edge as the final iteration
      prod_fix = neg_q ? -acc_nxt : acc_nxt;
      div_sel  = hi_q ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
      div_fix  = neg_q ? -div_sel : div_sel;

      acc_d    = acc_q;
      mb_d     = mb_q;
      res_d    = res_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      hi_d     = hi_q;

      if (start_i) begin
         if (spec_i) begin
            res_d = spec_res_i;
         end else begin
            is_div_d = funct3_i[2];
            // divide: hi selects remainder; multiply: hi selects upper word
            hi_d     = funct3_i[2] ? funct3_i[1] : (funct3_i != F3_MUL);
            // remainder follows the dividend, everything else is s1^s2
            neg_d    = (funct3_i[2] & funct3_i[1]) ? s1 : (s1 ^ s2);
            if (funct3_i[2]) begin
               mb_d  = mag2;
               acc_d = {{XLEN{1'b0}}, mag1};
            end else begin
               mb_d  = mag1;
               acc_d = {{XLEN{1'b0}}, mag2};
            end
         end
      end else if (step_i) begin
         acc_d = acc_nxt;
         if (finish_i) begin
            if (is_div_q)  res_d = div_fix;
            else if (hi_q) res_d = prod_fix[2*XLEN-1:XLEN];
            else           res_d = prod_fix[XLEN-1:0];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q    <= '0;
         mb_q     <= '0;
         res_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         hi_q     <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mb_q     <= mb_d;
         res_q    <= res_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
      end
   end

   assign result_o = res_q;

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl
//   Multi-cycle RV32M multiply/divide unit for the EX stage. Holds the
//   control FSM (IDLE/CALC/DONE), the iteration counter, divide special-case
//   detection and the start/done handshake; the arithmetic lives in
//   muldiv_core. XLEN must be >= 4 and even.
//   Ports:
//     clk_i, rst_i   clock, async active-high reset
//     valid_i        EX holds an M-type instruction
//     funct3_i       M operation
//     rs1_i, rs2_i   operands
//     flush_i        abort any in-flight operation
//     ready_o        unit idle
//     stall_o        freeze IF/ID/EX while the operation is running
//     done_o         one-cycle pulse, result_o valid
//     result_o       result, held until the next done_o
module alu_muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            ready_o,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int              CW       = $clog2(XLEN) + 1;
   localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
   localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            done_q, done_d, ready_q, ready_d;
   logic            accept, div_zero, div_ovf, special;
   logic            core_step, core_finish;
   logic [XLEN-1:0] spec_res;

   always_comb begin
      accept   = (state_q == ST_IDLE) & valid_i & ~flush_i;

      div_zero = funct3_i[2] & (rs2_i == '0);
      // only the signed ops (DIV/REM) can overflow
      div_ovf  = funct3_i[2] & ~funct3_i[0] & (rs1_i == SMIN) & (rs2_i == '1);
      special  = div_zero | div_ovf;

      // funct3[1] distinguishes remainder from quotient
      if (div_zero) spec_res = funct3_i[1] ? rs1_i : '1;
      else          spec_res = funct3_i[1] ? '0    : rs1_i;

      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_d   = CNT_INIT;
               state_d = special ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (flush_i) state_d = ST_IDLE;

      done_d      = (state_d == ST_DONE);
      ready_d     = (state_d == ST_IDLE);

      // flush must not let the last step overwrite the held result
      core_step   = (state_q == ST_CALC) & ~flush_i;
      core_finish = core_step & (cnt_q == CW'(1));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   muldiv_core #(.XLEN(XLEN)) u_core (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (accept),
      .step_i     (core_step),
      .finish_i   (core_finish),
      .funct3_i   (funct3_i),
      .rs1_i      (rs1_i),
      .rs2_i      (rs2_i),
      .spec_i     (special),
      .spec_res_i (spec_res),
      .result_o   (result_o)
   );

   // combinational in the accept cycle so the instruction is held in EX,
   // low in DONE so EX advances with the valid result
   assign stall_o = accept | (state_q == ST_CALC);
   assign ready_o = ready_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
module tb_alu_muldiv_ctrl;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            valid_i, flush_i;
   logic [2:0]      funct3_i;
   logic [XLEN-1:0] rs1_i, rs2_i;
   logic            ready_o, stall_o, done_o;
   logic [XLEN-1:0] result_o;

   alu_muldiv_ctrl #(.XLEN(XLEN)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .valid_i  (valid_i),
      .funct3_i (funct3_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .flush_i  (flush_i),
      .ready_o  (ready_o),
      .stall_o  (stall_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [31:0] last_res = '0;
   logic        meas = 1'b0;
   int          stall_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // reference model: plain 64-bit arithmetic on the RV32M definitions
   function automatic logic [31:0] ref_op(input int f3, input logic [31:0] a,
                                          input logic [31:0] b);
      longint          sa  = longint'($signed(a));
      longint          sb_ = longint'($signed(b));
      longint          ub  = longint'(b);
      longint unsigned uua = 64'(a);
      longint unsigned uub = 64'(b);
      logic [63:0]     p;
      logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         0: begin p = 64'(sa * sb_); return p[31:0];  end
         1: begin p = 64'(sa * sb_); return p[63:32]; end
         2: begin p = 64'(sa * ub);  return p[63:32]; end
         3: begin p = uua * uub;     return p[63:32]; end
         4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return a;
            return 32'($signed(a) / $signed(b));
         end
         5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         6: begin
            if (b == 0) return a;
            if (ovf)    return 32'd0;
            return 32'($signed(a) % $signed(b));
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input int f3, input logic [31:0] a,
                                     input logic [31:0] b);
      return (f3 >= 4 && b == 0) ||
             ((f3 == 4 || f3 == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 6))
         0, 1: return $urandom;
         2: return 32'($urandom_range(0, 20));
         3: return -32'($urandom_range(1, 20));
         4: return 32'd0;
         5: return 32'hFFFF_FFFF;
         default: return 32'h8000_0000;
      endcase
   endfunction

   // scoreboard monitor: every done_o must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && done_o) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done: got result %h expected no done", result_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", result_o, e.res);
            chk("done_cycle", 32'(cyc), 32'(e.due));
            last_res = e.res;
         end
      end
   end

   always @(negedge clk) if (meas && stall_o) stall_cnt++;

   task automatic wait_ready();
      int n = 0;
      while (!ready_o && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ready_timeout", {31'd0, ready_o}, 32'd1);
   endtask

   // present one instruction for its accept cycle; inputs change 1 time
   // unit after the edge and outputs are sampled on the falling edge
   task automatic issue(input int f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit push);
      wait_ready();
      funct3_i = 3'(f3);
      rs1_i    = a;
      rs2_i    = b;
      valid_i  = 1'b1;
      if (push) sb.push_back('{exp, cyc + (is_special(f3, a, b) ? 1 : XLEN + 1)});
      @(posedge clk); #1;
      valid_i  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
      funct3_i = '0; rs1_i = '0; rs2_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready",  {31'd0, ready_o}, 32'd1);
      chk("rst_done",   {31'd0, done_o},  32'd0);
      chk("rst_stall",  {31'd0, stall_o}, 32'd0);
      chk("rst_result", result_o,         32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // MUL 7 x -3 with stall duration measured
      stall_cnt = 0;
      meas = 1'b1;
      issue(0, 32'd7, -32'd3, 32'hFFFF_FFEB, 1);
      wait_ready();
      meas = 1'b0;
      chk("mul_stall_cycles", 32'(stall_cnt), 32'd33);

      issue(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
      issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1);
      issue(2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1);
      issue(4, -32'd7,        32'd2,         32'hFFFF_FFFD, 1);
      issue(6, -32'd7,        32'd2,         32'hFFFF_FFFF, 1);
      issue(5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 1);
      issue(5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      issue(6, 32'd5,         32'd0,         32'd5,         1);
      issue(4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      issue(6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
      wait_ready();

      // flush on the 10th CALC cycle: nothing may complete
      issue(0, 32'h1234_5678, 32'h0BAD_F00D, 32'd0, 0);
      repeat (9) begin @(posedge clk); #1; end
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      chk("flush_ready",  {31'd0, ready_o}, 32'd1);
      chk("flush_stall",  {31'd0, stall_o}, 32'd0);
      chk("flush_done",   {31'd0, done_o},  32'd0);
      chk("flush_result", result_o,         last_res);
      issue(0, 32'd3, 32'd4, 32'd12, 1);
      wait_ready();

      // asynchronous reset in the middle of CALC
      issue(4, 32'd1000, 32'd7, 32'd0, 0);
      repeat (5) begin @(posedge clk); end
      #3 rst = 1'b1;
      #1;
      chk("arst_ready",  {31'd0, ready_o}, 32'd1);
      chk("arst_done",   {31'd0, done_o},  32'd0);
      chk("arst_stall",  {31'd0, stall_o}, 32'd0);
      chk("arst_result", result_o,         32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      last_res = '0;
      issue(5, 32'd100, 32'd7, 32'd14, 1);

      // randomized operations against the reference model
      for (int i = 0; i < 60; i++) begin
         int          f3;
         logic [31:0] a, b;
         f3 = $urandom_range(0, 7);
         a  = rnd_opnd();
         b  = rnd_opnd();
         issue(f3, a, b, ref_op(f3, a, b), 1);
      end
      wait_ready();
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
